uart_rx_arbiter: RTL and testbench

//  Sole owner of the UART RX FIFO read port. Shares the received byte stream between three consumers:
//  BLE setup controller, connection monitor and payload processor. Grants one owner at a time from

---
 rtl/uart_rx_arb_pkg.sv | 30 +++
 rtl/rx_pattern_matcher.sv | 65 ++++++
 rtl/uart_rx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_rx_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_arb_pkg.sv
// Shared types and constants for the UART RX read-port arbiter.
package uart_rx_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_SETUP = 2'd1,
        OWN_MON   = 2'd2,
        OWN_PROC  = 2'd3
    } rx_owner_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_HOLD   = 2'd2,
        S_SWITCH = 2'd3
    } rx_arb_state_t;

    localparam int unsigned PAT_LEN = 7;
    localparam logic [PAT_LEN*8-1:0] DISC_STR = "OK+DISC";
    localparam logic [PAT_LEN*8-1:0] LOST_STR = "OK+LOST";

    // Character idx of a packed string, idx 0 being the leftmost character.
    function automatic logic [7:0] pat_char(input logic [PAT_LEN*8-1:0] str,
                                            input logic [2:0] idx);
        int unsigned pos;
        pos = (PAT_LEN - 1 - int'(idx)) * 8;
        return str[pos +: 8];
    endfunction

endpackage

// File: rtl/rx_pattern_matcher.sv
// Sniffs a byte stream for "OK+DISC" / "OK+LOST" and pulses match one cycle after the last byte.
module rx_pattern_matcher
    import uart_rx_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       match
);

    logic [2:0] idx_q, idx_d;
    logic       lost_q, lost_d;
    logic       match_q, match_d;
    logic [7:0] exp_char;

    always_comb begin
        exp_char = pat_char(lost_q ? LOST_STR : DISC_STR, idx_q);
    end

    always_comb begin
        idx_d   = idx_q;
        lost_d  = lost_q;
        match_d = 1'b0;
        if (clear) begin
            idx_d  = 3'd0;
            lost_d = 1'b0;
        end else if (byte_valid) begin
            // Position 3 is where the two strings diverge and picks the branch.
            if (idx_q == 3'd3 && byte_in == pat_char(DISC_STR, 3'd3)) begin
                idx_d  = 3'd4;
                lost_d = 1'b0;
            end else if (idx_q == 3'd3 && byte_in == pat_char(LOST_STR, 3'd3)) begin
                idx_d  = 3'd4;
                lost_d = 1'b1;
            end else if (idx_q != 3'd3 && byte_in == exp_char) begin
                if (idx_q == 3'(PAT_LEN - 1)) begin
                    match_d = 1'b1;
                    idx_d   = 3'd0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end else begin
                idx_d  = (byte_in == pat_char(DISC_STR, 3'd0)) ? 3'd1 : 3'd0;
                lost_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= 3'd0;
            lost_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            lost_q  <= lost_d;
            match_q <= match_d;
        end
    end

    assign match = match_q;

endmodule

// File: rtl/uart_rx_arbiter.sv
// Single owner of the UART RX FIFO read port; hands one byte at a time to setup, monitor or
// payload consumer and flags link loss seen in the payload stream.
module uart_rx_arbiter
    import uart_rx_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned STALL_CYCLES = 65536,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_rd_en,
    input  logic                  setup_done,
    input  logic                  link_up,
    output logic [DATA_WIDTH-1:0] byte_out,
    output logic                  setup_valid,
    input  logic                  setup_ready,
    output logic                  mon_valid,
    input  logic                  mon_ready,
    output logic                  proc_valid,
    input  logic                  proc_ready,
    output rx_owner_t             owner,
    output logic                  link_lost,
    output logic                  stall_drop,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    localparam int unsigned STALL_W = $clog2(STALL_CYCLES);

    rx_arb_state_t         state_q, state_d;
    rx_owner_t             owner_q, owner_d, req_owner;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [STALL_W-1:0]    stall_q, stall_d;
    logic [CNT_WIDTH-1:0]  drop_cnt_q;
    logic                  stall_drop_q;
    logic                  drop;
    logic                  owner_ready;
    logic                  in_hold;
    logic                  proc_hs;
    logic                  matcher_clear;

    always_comb begin
        if (!setup_done) begin
            req_owner = OWN_SETUP;
        end else if (!link_up) begin
            req_owner = OWN_MON;
        end else begin
            req_owner = OWN_PROC;
        end
    end

    always_comb begin
        owner_ready = 1'b0;
        case (owner_q)
            OWN_SETUP: owner_ready = setup_ready;
            OWN_MON:   owner_ready = mon_ready;
            OWN_PROC:  owner_ready = proc_ready;
            default:   owner_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        hold_d   = hold_q;
        stall_d  = stall_q;
        rx_rd_en = 1'b0;
        drop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_owner != owner_q) begin
                    state_d = S_SWITCH;
                end else if (rx_valid) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (rx_valid) begin
                    rx_rd_en = 1'b1;
                    hold_d   = rx_data;
                    stall_d  = '0;
                    state_d  = S_HOLD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                // Delivery beats owner change, which beats the stall timeout.
                if (owner_ready) begin
                    state_d = (req_owner != owner_q) ? S_SWITCH : S_IDLE;
                end else if (req_owner != owner_q) begin
                    drop    = 1'b1;
                    state_d = S_SWITCH;
                end else if (stall_q == STALL_W'(STALL_CYCLES - 1)) begin
                    drop    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            S_SWITCH: begin
                owner_d = req_owner;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_NONE;
            hold_q       <= '0;
            stall_q      <= '0;
            drop_cnt_q   <= '0;
            stall_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            hold_q       <= hold_d;
            stall_q      <= stall_d;
            stall_drop_q <= drop;
            if (drop && drop_cnt_q != {CNT_WIDTH{1'b1}}) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    assign in_hold       = (state_q == S_HOLD);
    assign setup_valid   = in_hold && (owner_q == OWN_SETUP);
    assign mon_valid     = in_hold && (owner_q == OWN_MON);
    assign proc_valid    = in_hold && (owner_q == OWN_PROC);
    assign proc_hs       = proc_valid && proc_ready;
    assign matcher_clear = (owner_q != OWN_PROC);
    assign byte_out      = hold_q;
    assign owner         = owner_q;
    assign stall_drop    = stall_drop_q;
    assign drop_cnt      = drop_cnt_q;

    rx_pattern_matcher u_matcher (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (matcher_clear),
        .byte_in    (hold_q[7:0]),
        .byte_valid (proc_hs),
        .match      (link_lost)
    );

endmodule

// File: tb/tb_uart_rx_arbiter.sv
// Self-checking bench for uart_rx_arbiter: vector table, directed corner cases, random payload run.
module tb_uart_rx_arbiter;
    import uart_rx_arb_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned STALL = 16;
    localparam int unsigned CW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_rd_en;
    logic          setup_done = 1'b0;
    logic          link_up = 1'b0;
    logic [DW-1:0] byte_out;
    logic          setup_valid, mon_valid, proc_valid;
    logic          setup_ready = 1'b0, mon_ready = 1'b0, proc_ready = 1'b0;
    rx_owner_t     owner;
    logic          link_lost, stall_drop;
    logic [CW-1:0] drop_cnt;

    always #5 clk = ~clk;

    uart_rx_arbiter #(
        .DATA_WIDTH   (DW),
        .STALL_CYCLES (STALL),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_rd_en    (rx_rd_en),
        .setup_done  (setup_done),
        .link_up     (link_up),
        .byte_out    (byte_out),
        .setup_valid (setup_valid),
        .setup_ready (setup_ready),
        .mon_valid   (mon_valid),
        .mon_ready   (mon_ready),
        .proc_valid  (proc_valid),
        .proc_ready  (proc_ready),
        .owner       (owner),
        .link_lost   (link_lost),
        .stall_drop  (stall_drop),
        .drop_cnt    (drop_cnt)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- UART FIFO model ----------------
    logic [7:0] fifo[$];
    logic       pop_seen = 1'b0;

    initial begin
        rx_valid = 1'b0;
        rx_data  = '0;
        forever begin
            @(posedge clk);
            if (pop_seen && fifo.size() > 0) void'(fifo.pop_front());
            #1;
            rx_valid = (fifo.size() > 0);
            rx_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
        end
    end

    // ---------------- Reference link-loss detector ----------------
    string m_pfx = "";

    function automatic bit is_pre(input string c, input string s);
        if (c.len() > s.len()) return 1'b0;
        return s.substr(0, c.len() - 1) == c;
    endfunction

    function automatic bit feed(input logic [7:0] b);
        string cand;
        cand = $sformatf("%s%c", m_pfx, b);
        if (cand == "OK+DISC" || cand == "OK+LOST") begin
            m_pfx = "";
            return 1'b1;
        end
        if (is_pre(cand, "OK+DISC") || is_pre(cand, "OK+LOST")) m_pfx = cand;
        else m_pfx = (b == 8'h4F) ? "O" : "";
        return 1'b0;
    endfunction

    // ---------------- Monitor ----------------
    rx_owner_t  hs_ch[$];
    logic [7:0] hs_b[$];
    int  cyc = 0, last_pop_cyc = 0, last_hs_cyc = 0;
    int  n_pops = 0, n_drops = 0, n_lost = 0, n_pvalid = 0;
    bit  prev_pop = 1'b0, exp_lost = 1'b0;

    initial begin
        forever begin
            int        nv;
            bit        hit;
            rx_owner_t vch;
            @(negedge clk);
            cyc++;
            pop_seen = rx_rd_en && rst_n;
            if (!rst_n) begin
                exp_lost = 1'b0;
                prev_pop = 1'b0;
                m_pfx    = "";
                continue;
            end
            if (rx_rd_en) begin
                check("pop_has_data", 32'(rx_valid), 32'd1);
                check("pop_spacing", 32'(prev_pop), 32'd0);
                n_pops++;
                last_pop_cyc = cyc;
            end
            prev_pop = rx_rd_en;
            nv = int'(setup_valid) + int'(mon_valid) + int'(proc_valid);
            if (nv != 0) begin
                check("one_valid", 32'(nv), 32'd1);
                vch = setup_valid ? OWN_SETUP : (mon_valid ? OWN_MON : OWN_PROC);
                check("valid_owner", 32'(owner), 32'(vch));
            end
            hit = 1'b0;
            if (setup_valid && setup_ready) begin
                hs_ch.push_back(OWN_SETUP); hs_b.push_back(byte_out); last_hs_cyc = cyc;
            end
            if (mon_valid && mon_ready) begin
                hs_ch.push_back(OWN_MON); hs_b.push_back(byte_out); last_hs_cyc = cyc;
            end
            if (proc_valid && proc_ready) begin
                hs_ch.push_back(OWN_PROC); hs_b.push_back(byte_out); last_hs_cyc = cyc;
                hit = feed(byte_out);
            end
            check("link_lost", 32'(link_lost), 32'(exp_lost));
            exp_lost = hit;
            if (stall_drop) n_drops++;
            if (link_lost)  n_lost++;
            if (proc_valid) n_pvalid++;
            if (!(setup_done && link_up)) m_pfx = "";
        end
    end

    // ---------------- Helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) fifo.push_back(s.getc(i));
    endtask

    task automatic expect_hs(input string name, input rx_owner_t ch, input logic [7:0] b);
        int         n;
        rx_owner_t  gch;
        logic [7:0] gb;
        n = 0;
        while (hs_ch.size() == 0 && n < 200) begin
            tick(1);
            n++;
        end
        if (hs_ch.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: no handshake within 200 cycles, expected byte 0x%0h", name, b);
        end else begin
            gch = hs_ch.pop_front();
            gb  = hs_b.pop_front();
            check({name, "_ch"}, 32'(gch), 32'(ch));
            check({name, "_byte"}, 32'(gb), 32'(b));
        end
    endtask

    task automatic expect_str(input string name, input rx_owner_t ch, input string s);
        for (int i = 0; i < s.len(); i++) expect_hs($sformatf("%s_%0d", name, i), ch, s.getc(i));
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!(setup_valid || mon_valid || proc_valid) && n < 100) begin
            tick(1);
            n++;
        end
        if (!(setup_valid || mon_valid || proc_valid)) begin
            checks++;
            failures++;
            $display("FAIL %s: no valid within 100 cycles, got none, expected one", name);
        end
    endtask

    typedef struct {
        logic       sd;
        logic       lu;
        logic [7:0] b;
        rx_owner_t  ch;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- Main sequence ----------------
    initial begin
        int base, n;
        string alpha;
        logic [7:0] exp_q[$];
        logic [7:0] rb;

        vecs[0] = '{1'b0, 1'b0, 8'h5A, OWN_SETUP};
        vecs[1] = '{1'b1, 1'b0, 8'h4F, OWN_MON};
        vecs[2] = '{1'b1, 1'b0, 8'h0D, OWN_MON};
        vecs[3] = '{1'b1, 1'b1, 8'h33, OWN_PROC};
        vecs[4] = '{1'b1, 1'b1, 8'hFF, OWN_PROC};
        vecs[5] = '{1'b0, 1'b1, 8'h00, OWN_SETUP};
        vecs[6] = '{1'b1, 1'b0, 8'hA5, OWN_MON};

        // Reset values
        tick(3);
        check("rst_rd_en", 32'(rx_rd_en), 32'd0);
        check("rst_valids", {29'd0, setup_valid, mon_valid, proc_valid}, 32'd0);
        check("rst_byte_out", 32'(byte_out), 32'd0);
        check("rst_owner", 32'(owner), 32'(OWN_NONE));
        check("rst_link_lost", 32'(link_lost), 32'd0);
        check("rst_stall_drop", 32'(stall_drop), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;

        // Single byte to setup: one pop, valid the cycle after the pop
        setup_ready = 1'b1; mon_ready = 1'b1; proc_ready = 1'b1;
        fifo.push_back(8'h41);
        expect_hs("t1", OWN_SETUP, 8'h41);
        check("t1_pops", 32'(n_pops), 32'd1);
        check("t1_latency", 32'(last_hs_cyc - last_pop_cyc), 32'd1);
        check("t1_owner", 32'(owner), 32'(OWN_SETUP));

        // Vector table: owner selection from setup_done/link_up
        foreach (vecs[i]) begin
            setup_done = vecs[i].sd;
            link_up    = vecs[i].lu;
            fifo.push_back(vecs[i].b);
            expect_hs($sformatf("vec%0d", i), vecs[i].ch, vecs[i].b);
            check($sformatf("vec%0d_owner", i), 32'(owner), 32'(vecs[i].ch));
        end

        // Monitor gets a whole AT response, processor nothing
        setup_done = 1'b1; link_up = 1'b0;
        push_str("OK+CONN:010203040506\r\n");
        expect_str("t2", OWN_MON, "OK+CONN:010203040506\r\n");

        // Payload with disconnect string
        link_up = 1'b1;
        base = n_lost;
        push_str("xyOK+DISC\r\n");
        expect_str("t3", OWN_PROC, "xyOK+DISC\r\n");
        tick(3);
        check("t3_lost_pulses", 32'(n_lost - base), 32'd1);

        base = n_lost;
        push_str("OOK+LOST");
        expect_str("t4a", OWN_PROC, "OOK+LOST");
        tick(3);
        check("t4a_lost_pulses", 32'(n_lost - base), 32'd1);
        base = n_lost;
        push_str("OK+LOSX");
        expect_str("t4b", OWN_PROC, "OK+LOSX");
        tick(3);
        check("t4b_lost_pulses", 32'(n_lost - base), 32'd0);

        // Stall timeout drop
        proc_ready = 1'b0;
        base = n_pvalid;
        fifo.push_back(8'h99);
        n = 0;
        while (n_drops == 0 && n < 100) begin
            tick(1);
            n++;
        end
        tick(2);
        check("t5_valid_cycles", 32'(n_pvalid - base), STALL);
        check("t5_drops", 32'(n_drops), 32'd1);
        check("t5_drop_cnt", 32'(drop_cnt), 32'd1);
        check("t5_no_hs", 32'(hs_ch.size()), 32'd0);
        proc_ready = 1'b1;

        // Ready and owner change in the same cycle: delivery wins, then one bubble
        link_up = 1'b0;
        mon_ready = 1'b0;
        fifo.push_back(8'h55);
        wait_valid("t6_wait");
        check("t6_mon_valid", 32'(mon_valid), 32'd1);
        link_up = 1'b1;
        mon_ready = 1'b1;
        tick(1);
        mon_ready = 1'b0;
        check("t6_owner_bubble", 32'(owner), 32'(OWN_MON));
        tick(1);
        check("t6_owner_proc", 32'(owner), 32'(OWN_PROC));
        expect_hs("t6", OWN_MON, 8'h55);
        check("t6_drop_cnt", 32'(drop_cnt), 32'd1);
        mon_ready = 1'b1;

        // Owner change while holding: byte dropped
        proc_ready = 1'b0;
        fifo.push_back(8'h66);
        wait_valid("t7_wait");
        link_up = 1'b0;
        tick(1);
        check("t7_stall_drop", 32'(stall_drop), 32'd1);
        check("t7_drop_cnt", 32'(drop_cnt), 32'd2);
        tick(1);
        check("t7_owner", 32'(owner), 32'(OWN_MON));
        check("t7_pulse_width", 32'(stall_drop), 32'd0);
        check("t7_no_hs", 32'(hs_ch.size()), 32'd0);

        // Drop counter saturation
        link_up = 1'b1;
        base = n_drops;
        for (int i = 0; i < 260; i++) fifo.push_back(8'(i));
        n = 0;
        while ((n_drops - base) < 260 && n < 260 * 25) begin
            tick(1);
            n++;
        end
        tick(2);
        check("t8_drops", 32'(n_drops - base), 32'd260);
        check("t8_drop_cnt_sat", 32'(drop_cnt), 32'd255);
        check("t8_no_hs", 32'(hs_ch.size()), 32'd0);

        // Random payload stream with random back-pressure
        alpha = "OK+DISCLTx";
        for (int i = 0; i < 300; i++) begin
            rb = alpha.getc($urandom_range(0, 9));
            fifo.push_back(rb);
            exp_q.push_back(rb);
        end
        n = 0;
        while (exp_q.size() > 0 && n < 6000) begin
            proc_ready = ($urandom_range(0, 3) != 0);
            tick(1);
            n++;
            while (hs_ch.size() > 0 && exp_q.size() > 0) begin
                rx_owner_t  gch;
                logic [7:0] gb, eb;
                gch = hs_ch.pop_front();
                gb  = hs_b.pop_front();
                eb  = exp_q.pop_front();
                check("rnd_ch", 32'(gch), 32'(OWN_PROC));
                check("rnd_byte", 32'(gb), 32'(eb));
            end
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL rnd_timeout: %0d bytes undelivered, expected 0", exp_q.size());
        end
        proc_ready = 1'b1;
        tick(3);
        check("rnd_drop_cnt", 32'(drop_cnt), 32'd255);

        // Asynchronous reset while a byte is held
        proc_ready = 1'b0;
        fifo.push_back(8'h77);
        wait_valid("t9_wait");
        rst_n = 1'b0;
        #1;
        check("t9_valid", 32'(proc_valid), 32'd0);
        check("t9_owner", 32'(owner), 32'(OWN_NONE));
        check("t9_drop_cnt", 32'(drop_cnt), 32'd0);
        check("t9_byte_out", 32'(byte_out), 32'd0);
        tick(1);
        rst_n = 1'b1;
        proc_ready = 1'b1;
        tick(4);
        check("t9_owner_after", 32'(owner), 32'(OWN_PROC));
        check("t9_no_hs", 32'(hs_ch.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
